// File: rtl/sonic_defs.sv
// sonic_defs: shared FSM encoding and default HC-SR04 timing at 50 MHz.
// Imported by the echo emulator and the measurement block.
package sonic_defs;

  localparam int unsigned CNT_W_DEF       = 21;
  localparam int unsigned TRIG_MIN_DEF    = 500;
  localparam int unsigned BURST_DELAY_DEF = 11500;
  localparam int unsigned TIMEOUT_DEF     = 1900000;
  localparam int unsigned HOLDOFF_DEF     = 500000;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG_HI = 3'd1;
  localparam logic [2:0] ST_DELAY   = 3'd2;
  localparam logic [2:0] ST_ECHO    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;

endpackage

// File: rtl/sonic_echo_emulator_if.sv
// sonic_echo_if: trig/echo link between measurement block (master)
// and sensor/emulator (slave); trig, echo_len, echo, busy, shot_count.
interface sonic_echo_if #(
  parameter int unsigned CNT_W = 21
);

  logic             trig;
  logic [CNT_W-1:0] echo_len;
  logic             echo;
  logic             busy;
  logic [15:0]      shot_count;

  modport master (
    output trig,
    output echo_len,
    input  echo,
    input  busy,
    input  shot_count
  );

  modport slave (
    input  trig,
    input  echo_len,
    output echo,
    output busy,
    output shot_count
  );

endinterface

// File: rtl/sonic_echo_emulator_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async active-low reset to 0.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sonic_echo_emulator.sv
// sonic_echo_emulator: HC-SR04 responder; answers a valid trig with an
// echo of echo_len cycles. Ports: clock, reset_n, bus (slave modport).
module sonic_echo_emulator
  import sonic_defs::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TRIG_MIN    = TRIG_MIN_DEF,
  parameter int unsigned BURST_DELAY = BURST_DELAY_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF,
  parameter int unsigned HOLDOFF     = HOLDOFF_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  sonic_echo_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMIN  = CNT_W'(TRIG_MIN);
  localparam logic [CNT_W-1:0] BDLY  = CNT_W'(BURST_DELAY);
  localparam logic [CNT_W-1:0] TOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD  = CNT_W'(HOLDOFF);

  logic             trig_s;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             echo_q, echo_d;
  logic             busy_q, busy_d;
  logic [15:0]      shot_q, shot_d;
  logic [CNT_W-1:0] len_sel;

  sync_2ff u_trig_sync (
    .clk   (clock),
    .rst_n (reset_n),
    .d     (bus.trig),
    .q     (trig_s)
  );

  // Zero means "no object"; anything longer than the timeout is clamped.
  always_comb begin
    len_sel = bus.echo_len;
    if (bus.echo_len == '0 || bus.echo_len > TOUT) begin
      len_sel = TOUT;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    echo_d  = echo_q;
    shot_d  = shot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_s) begin
          state_d = ST_TRIG_HI;
          cnt_d   = ONE;
        end
      end
      ST_TRIG_HI: begin
        if (trig_s) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + ONE;
          end
        end else if (cnt_q >= TMIN) begin
          state_d = ST_DELAY;
          cnt_d   = ONE;
          len_d   = len_sel;
          shot_d  = shot_q + 16'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DELAY: begin
        if (cnt_q == BDLY) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_ECHO: begin
        if (cnt_q == len_q) begin
          state_d = ST_HOLD;
          echo_d  = 1'b0;
          cnt_d   = ONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HOLD) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        echo_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      shot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      shot_q  <= shot_d;
    end
  end

  assign bus.echo       = echo_q;
  assign bus.busy       = busy_q;
  assign bus.shot_count = shot_q;

endmodule
